// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/acknowledge bus between the MEM-stage LSU and memory.
interface mem_stage_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives the data bus, stalls on wait states,
// aborts misaligned or timed-out accesses and fills the MEM/WB register.
//
// state  | meaning
// IDLE   | no access outstanding; a request may complete in its first cycle
// WAIT   | request issued, waiting for ack; wcnt counts wait cycles
module mem_stage_lsu #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ValidM,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  input  logic [31:0]           ALUResultM,
  input  logic [31:0]           WriteDataM,
  input  logic [4:0]            RdM,
  input  logic [31:0]           PCPlus4M,
  output logic                  StallM,
  mem_stage_lsu_if.master       dmem,
  output logic                  ValidW,
  output logic [31:0]           ALUResultW,
  output logic [31:0]           ReadDataW,
  output logic [4:0]            RdW,
  output logic [31:0]           PCPlus4W,
  output logic                  MisalignW,
  output logic                  BusErrW
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wcnt_q, wcnt_d;

  logic        valid_w_q;
  logic [31:0] alu_w_q;
  logic [31:0] rdata_w_q;
  logic [4:0]  rd_w_q;
  logic [31:0] pc4_w_q;
  logic        misalign_w_q;
  logic        buserr_w_q;

  logic        mem_op, is_byte, is_half, is_word;
  logic        misaligned, req, timeout, ack;
  logic [31:0] wdata_lane;
  logic [3:0]  be_lane;
  logic [31:0] rdata_shift;
  logic [31:0] load_data;
  logic        sext;

  // Access decode, misalignment check, stall and timeout detection
  always_comb begin
    mem_op     = ValidM & (MemReadM | MemWriteM);
    is_byte    = (Funct3M[1:0] == 2'b00);
    is_half    = (Funct3M[1:0] == 2'b01);
    is_word    = !is_byte && !is_half;
    misaligned = mem_op & ((is_half & ALUResultM[0]) |
                           (is_word & (ALUResultM[1:0] != 2'b00)));
    req        = mem_op & !misaligned;
    ack        = dmem.dmem_ack;
    timeout    = req & (state_q == S_WAIT) & (wcnt_q == WAIT_LAST) & !ack;
    StallM     = req & !ack & !timeout;
  end

  // Store lane steering; byte enables only valid while requesting
  always_comb begin
    wdata_lane = WriteDataM;
    be_lane    = 4'b1111;
    if (is_byte) begin
      wdata_lane = {4{WriteDataM[7:0]}};
      be_lane    = 4'b0001 << ALUResultM[1:0];
    end else if (is_half) begin
      wdata_lane = {2{WriteDataM[15:0]}};
      be_lane    = ALUResultM[1] ? 4'b1100 : 4'b0011;
    end
  end

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = req & MemWriteM;
  assign dmem.dmem_addr  = {ALUResultM[31:2], 2'b00};
  assign dmem.dmem_wdata = wdata_lane;
  assign dmem.dmem_be    = req ? be_lane : 4'b0000;

  // Load extract: shift the addressed lane down, then sign/zero extend
  always_comb begin
    rdata_shift = dmem.dmem_rdata >> {ALUResultM[1:0], 3'b000};
    sext        = !Funct3M[2];
    load_data   = dmem.dmem_rdata;
    if (is_byte) begin
      load_data = {{24{sext & rdata_shift[7]}}, rdata_shift[7:0]};
    end else if (is_half) begin
      load_data = {{16{sext & rdata_shift[15]}}, rdata_shift[15:0]};
    end
  end

  // Next-state logic for the wait FSM
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (req && !ack) begin
          state_d = S_WAIT;
          wcnt_d  = 8'd0;
        end
      end
      S_WAIT: begin
        // Dropping req here only happens when upstream was flushed
        if (!req || ack || timeout) begin
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and wait counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // MEM/WB capture; a stall cycle inserts a bubble and holds the data fields
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_w_q    <= 1'b0;
      alu_w_q      <= 32'd0;
      rdata_w_q    <= 32'd0;
      rd_w_q       <= 5'd0;
      pc4_w_q      <= 32'd0;
      misalign_w_q <= 1'b0;
      buserr_w_q   <= 1'b0;
    end else if (StallM) begin
      valid_w_q    <= 1'b0;
      misalign_w_q <= 1'b0;
      buserr_w_q   <= 1'b0;
    end else begin
      valid_w_q    <= ValidM & !misaligned & !timeout;
      alu_w_q      <= ALUResultM;
      rdata_w_q    <= (req & ack & MemReadM) ? load_data : 32'd0;
      rd_w_q       <= RdM;
      pc4_w_q      <= PCPlus4M;
      misalign_w_q <= misaligned;
      buserr_w_q   <= timeout;
    end
  end

  assign ValidW     = valid_w_q;
  assign ALUResultW = alu_w_q;
  assign ReadDataW  = rdata_w_q;
  assign RdW        = rd_w_q;
  assign PCPlus4W   = pc4_w_q;
  assign MisalignW  = misalign_w_q;
  assign BusErrW    = buserr_w_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: each op's MEM/WB result is queued when
// driven and compared when the stage retires it.
module tb_mem_stage_lsu;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ValidM, MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        StallM;
  logic        ValidW, MisalignW, BusErrW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;

  mem_stage_lsu_if dmem_if ();

  mem_stage_lsu #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .ValidM     (ValidM),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .RdM        (RdM),
    .PCPlus4M   (PCPlus4M),
    .StallM     (StallM),
    .dmem       (dmem_if),
    .ValidW     (ValidW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .RdW        (RdW),
    .PCPlus4W   (PCPlus4W),
    .MisalignW  (MisalignW),
    .BusErrW    (BusErrW)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic        mis;
    logic        berr;
  } wexp_t;

  wexp_t sb_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // 0 = byte, 1 = half, 2 = word
  function automatic int ref_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 0;
      3'b001, 3'b101: return 1;
      default:        return 2;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0: b = d[7:0];
      2'd1: b = d[15:8];
      2'd2: b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000: return b[7]  ? {24'hFFFFFF, b} : {24'h0, b};
      3'b100: return {24'h0, b};
      3'b001: return h[15] ? {16'hFFFF, h} : {16'h0, h};
      3'b101: return {16'h0, h};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (ref_size(f3))
      0: return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      1: return {wd[15:0], wd[15:0]};
      default: return wd;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] a);
    case (ref_size(f3))
      0: case (a)
           2'd0: return 4'b0001;
           2'd1: return 4'b0010;
           2'd2: return 4'b0100;
           default: return 4'b1000;
         endcase
      1: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic check_w_zero(input string name);
    check_eq({name, ".ValidW"},     32'(ValidW),    32'd0);
    check_eq({name, ".ALUResultW"}, ALUResultW,     32'd0);
    check_eq({name, ".ReadDataW"},  ReadDataW,      32'd0);
    check_eq({name, ".RdW"},        32'(RdW),       32'd0);
    check_eq({name, ".PCPlus4W"},   PCPlus4W,       32'd0);
    check_eq({name, ".MisalignW"},  32'(MisalignW), 32'd0);
    check_eq({name, ".BusErrW"},    32'(BusErrW),   32'd0);
  endtask

  // Called just after a rising edge. ack_at: cycle index of the ack (0 = same
  // cycle as the request); anything outside 0..MAX_WAIT means no ack.
  task automatic run_op(input string name, input logic v, input logic rd_en, input logic wr_en,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rdi, input logic [31:0] pc4,
                        input int ack_at, input logic [31:0] rdata);
    logic  memop, mis, req_e, acked, to, stall_e;
    int    sz;
    wexp_t e, got;
    sz    = ref_size(f3);
    memop = v & (rd_en | wr_en);
    mis   = memop & (((sz == 1) && addr[0]) || ((sz == 2) && (addr[1:0] != 2'b00)));
    req_e = memop & !mis;
    acked = req_e && (ack_at >= 0) && (ack_at <= MAX_WAIT);
    to    = req_e && !acked;
    e.valid = v & !mis & !to;
    e.alu   = addr;
    e.rdata = (acked && rd_en) ? ref_load(f3, addr[1:0], rdata) : 32'd0;
    e.rd    = rdi;
    e.pc4   = pc4;
    e.mis   = mis;
    e.berr  = to;
    sb_q.push_back(e);

    ValidM = v; MemReadM = rd_en; MemWriteM = wr_en; Funct3M = f3;
    ALUResultM = addr; WriteDataM = wd; RdM = rdi; PCPlus4M = pc4;

    for (int k = 0; k <= MAX_WAIT + 1; k++) begin
      dmem_if.dmem_ack   = (k == ack_at);
      dmem_if.dmem_rdata = (k == ack_at) ? rdata : $urandom;
      #4;
      stall_e = req_e && (k != ack_at) && !(to && (k == MAX_WAIT));
      check_eq({name, ".req"},   32'(dmem_if.dmem_req), 32'(req_e));
      check_eq({name, ".stall"}, 32'(StallM),           32'(stall_e));
      if (req_e) begin
        check_eq({name, ".addr"}, dmem_if.dmem_addr,   {addr[31:2], 2'b00});
        check_eq({name, ".we"},   32'(dmem_if.dmem_we), 32'(wr_en));
        if (wr_en) begin
          check_eq({name, ".wdata"}, dmem_if.dmem_wdata,  ref_wdata(f3, wd));
          check_eq({name, ".be"},    32'(dmem_if.dmem_be), 32'(ref_be(f3, addr[1:0])));
        end
      end else begin
        check_eq({name, ".we_idle"}, 32'(dmem_if.dmem_we), 32'd0);
        check_eq({name, ".be_idle"}, 32'(dmem_if.dmem_be), 32'd0);
      end
      @(posedge clk);
      #1;
      if (stall_e) begin
        check_eq({name, ".bubble"}, 32'(ValidW), 32'd0);
      end else begin
        check_eq({name, ".sb_depth"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) begin
          got = sb_q.pop_front();
          check_eq({name, ".ValidW"},     32'(ValidW),    32'(got.valid));
          check_eq({name, ".ALUResultW"}, ALUResultW,     got.alu);
          check_eq({name, ".ReadDataW"},  ReadDataW,      got.rdata);
          check_eq({name, ".RdW"},        32'(RdW),       32'(got.rd));
          check_eq({name, ".PCPlus4W"},   PCPlus4W,       got.pc4);
          check_eq({name, ".MisalignW"},  32'(MisalignW), 32'(got.mis));
          check_eq({name, ".BusErrW"},    32'(BusErrW),   32'(got.berr));
        end
        break;
      end
    end
    dmem_if.dmem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3_tab [6];
    logic [2:0]  rf3;
    logic [31:0] raddr;
    int          kind;

    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
    reset = 1'b0;
    ValidM = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
    ALUResultM = 32'd0; WriteDataM = 32'd0; RdM = 5'd0; PCPlus4M = 32'd0;
    dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    check_w_zero("reset");
    check_eq("reset.stall", 32'(StallM), 32'd0);
    check_eq("reset.req",   32'(dmem_if.dmem_req), 32'd0);
    reset = 1'b1;

    run_op("lb_zero_wait", 1, 1, 0, 3'b000, 32'h0000_0103, 32'h0, 5'd1, 32'h0000_1004, 0, 32'h80FF_FFFF);
    run_op("sh_wait",      1, 0, 1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 5'd0, 32'h0000_1008, 2, 32'h0);
    run_op("lw_misalign",  1, 1, 0, 3'b010, 32'h0000_0101, 32'h0, 5'd2, 32'h0000_100C, 0, 32'hDEAD_BEEF);
    run_op("nop_invalid",  0, 1, 0, 3'b010, 32'h0000_0100, 32'h0, 5'd3, 32'h0000_1010, 0, 32'h1111_1111);
    run_op("lw_timeout",   1, 1, 0, 3'b010, 32'h0000_0500, 32'h0, 5'd4, 32'h0000_1014, -1, 32'h0);
    run_op("late_ack",     0, 0, 0, 3'b000, 32'h0000_0000, 32'h0, 5'd0, 32'h0000_1018, 0, 32'hCAFE_F00D);
    run_op("lhu",          1, 1, 0, 3'b101, 32'h0000_0302, 32'h0, 5'd5, 32'h0000_101C, 1, 32'h8001_0000);
    run_op("alu_op",       1, 0, 0, 3'b000, 32'h0000_0055, 32'h0, 5'd7, 32'h0000_1020, 0, 32'h0);
    run_op("sb_lane1",     1, 0, 1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 5'd0, 32'h0000_1024, 0, 32'h0);
    run_op("sw",           1, 0, 1, 3'b010, 32'h0000_0204, 32'h89AB_CDEF, 5'd0, 32'h0000_1028, 1, 32'h0);
    run_op("lh_neg",       1, 1, 0, 3'b001, 32'h0000_0100, 32'h0, 5'd8, 32'h0000_102C, 1, 32'h1234_F00D);
    run_op("lbu",          1, 1, 0, 3'b100, 32'h0000_0102, 32'h0, 5'd9, 32'h0000_1030, 0, 32'h00C3_0000);
    run_op("lw_max_wait",  1, 1, 0, 3'b010, 32'h0000_0208, 32'h0, 5'd10, 32'h0000_1034, MAX_WAIT, 32'h7654_3210);
    run_op("f3_011_as_w",  1, 1, 0, 3'b011, 32'h0000_0302, 32'h0, 5'd11, 32'h0000_1038, 0, 32'h1);
    run_op("sh_misalign",  1, 0, 1, 3'b001, 32'h0000_0303, 32'hFFFF, 5'd0, 32'h0000_103C, 0, 32'h0);

    // Reset on the second WAIT cycle of an unacknowledged load
    ValidM = 1; MemReadM = 1; MemWriteM = 0; Funct3M = 3'b010;
    ALUResultM = 32'h0000_0400; RdM = 5'd12; PCPlus4M = 32'h0000_1040;
    dmem_if.dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("rst_wait.stall",  32'(StallM), 32'd1);
    check_eq("rst_wait.bubble", 32'(ValidW), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_w_zero("rst_wait");
    reset = 1'b1;
    run_op("rst_late_ack", 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0, 0, 32'h5555_5555);
    run_op("lw_after_rst", 1, 1, 0, 3'b010, 32'h0000_0404, 32'h0, 5'd13, 32'h0000_1044, 3, 32'hA5A5_5A5A);

    for (int i = 0; i < 16; i++) begin
      kind  = int'($urandom_range(0, 2));
      rf3   = f3_tab[$urandom_range(0, 5)];
      raddr = $urandom;
      run_op("rand", 1, kind == 1, kind == 2, rf3, raddr, $urandom, 5'($urandom_range(1, 31)),
             32'h0000_2000 + 32'(i * 4), int'($urandom_range(0, MAX_WAIT + 1)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
